// File: rtl/mips_multi_cycle_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_multi_cycle_core
// Purpose  : Self-contained multi-cycle MIPS core. Unified instruction/data
//            memory, 32x32 register file, integrated control FSM, and a
//            memory-mapped GPIO output register.
//            Supported: lw sw add sub and or slt beq bne addi ori lui j.
//            Any other opcode or funct parks the FSM in HALT until reset.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-high reset
//            GPIO_o   - registered GPIO output (GPIO_W bits)
//            pc_o     - current PC register
//            state_o  - current FSM state encoding (debug)
//            halted_o - high while the FSM is in HALT
// Revision : 1.0 - initial release
// ============================================================================
module mips_multi_cycle_core #(
    parameter int          MEM_DEPTH = 64,
    parameter int          GPIO_W    = 8,
    parameter logic [31:0] GPIO_ADDR = 32'h0000_0FFC,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [GPIO_W-1:0] GPIO_o,
    output logic [31:0]       pc_o,
    output logic [3:0]        state_o,
    output logic              halted_o
);
    localparam int c_AW = $clog2(MEM_DEPTH);

    localparam logic [3:0] c_S_FETCH  = 4'd0,  c_S_DECODE = 4'd1,  c_S_MEMADR = 4'd2,
                           c_S_MEMRD  = 4'd3,  c_S_MEMWB  = 4'd4,  c_S_MEMWR  = 4'd5,
                           c_S_EXEC   = 4'd6,  c_S_ALUWB  = 4'd7,  c_S_BRANCH = 4'd8,
                           c_S_IMMEX  = 4'd9,  c_S_IMMWB  = 4'd10, c_S_JUMP   = 4'd11,
                           c_S_HALT   = 4'd15;

    localparam logic [5:0] c_OP_RTYPE = 6'h00, c_OP_J    = 6'h02, c_OP_BEQ = 6'h04,
                           c_OP_BNE   = 6'h05, c_OP_ADDI = 6'h08, c_OP_ORI = 6'h0D,
                           c_OP_LUI   = 6'h0F, c_OP_LW   = 6'h23, c_OP_SW  = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20, c_FN_SUB = 6'h22, c_FN_AND = 6'h24,
                           c_FN_OR  = 6'h25, c_FN_SLT = 6'h2A;

    // Architectural and pipeline registers
    logic [3:0]        r_state;
    logic [31:0]       r_pc, r_ir, r_mdr, r_a, r_b, r_alu_out;
    logic [GPIO_W-1:0] r_gpio;
    logic [31:0]       r_regs [32];
    logic [31:0]       r_mem  [MEM_DEPTH];

    // Instruction fields and derived operands
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_sext, w_zext, w_rs_val, w_rt_val;
    logic [31:0] w_mem_pc_word, w_mem_alu_word, w_diff;
    logic [31:0] w_r_result, w_imm_result;
    logic        w_funct_ok, w_br_taken, w_gpio_hit;

    assign w_opcode = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_imm    = r_ir[15:0];
    assign w_sext   = {{16{w_imm[15]}}, w_imm};
    assign w_zext   = {16'h0000, w_imm};

    assign w_rs_val = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];

    // Word-addressed memory; the byte offset bits are ignored and upper bits alias.
    assign w_mem_pc_word  = r_mem[r_pc[c_AW+1:2]];
    assign w_mem_alu_word = r_mem[r_alu_out[c_AW+1:2]];

    assign w_diff     = r_a - r_b;
    assign w_br_taken = (w_opcode == c_OP_BNE) ? (w_diff != 32'h0) : (w_diff == 32'h0);
    assign w_gpio_hit = (r_alu_out == GPIO_ADDR);

    always_comb begin
        w_funct_ok = 1'b1;
        w_r_result = 32'h0;
        case (w_funct)
            c_FN_ADD: w_r_result = r_a + r_b;
            c_FN_SUB: w_r_result = r_a - r_b;
            c_FN_AND: w_r_result = r_a & r_b;
            c_FN_OR:  w_r_result = r_a | r_b;
            c_FN_SLT: w_r_result = {31'h0, ($signed(r_a) < $signed(r_b))};
            default:  w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (w_opcode)
            c_OP_ORI: w_imm_result = r_a | w_zext;
            c_OP_LUI: w_imm_result = {w_imm, 16'h0000};
            default:  w_imm_result = r_a + w_sext;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    logic [3:0] w_next_state;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_S_FETCH;
        else       r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_FETCH:  w_next_state = c_S_DECODE;
            c_S_DECODE: begin
                case (w_opcode)
                    c_OP_LW, c_OP_SW:              w_next_state = c_S_MEMADR;
                    c_OP_RTYPE:                    w_next_state = c_S_EXEC;
                    c_OP_BEQ, c_OP_BNE:            w_next_state = c_S_BRANCH;
                    c_OP_ADDI, c_OP_ORI, c_OP_LUI: w_next_state = c_S_IMMEX;
                    c_OP_J:                        w_next_state = c_S_JUMP;
                    default:                       w_next_state = c_S_HALT;
                endcase
            end
            c_S_MEMADR: w_next_state = (w_opcode == c_OP_LW) ? c_S_MEMRD : c_S_MEMWR;
            c_S_MEMRD:  w_next_state = c_S_MEMWB;
            c_S_EXEC:   w_next_state = w_funct_ok ? c_S_ALUWB : c_S_HALT;
            c_S_IMMEX:  w_next_state = c_S_IMMWB;
            c_S_MEMWB, c_S_MEMWR, c_S_ALUWB, c_S_IMMWB,
            c_S_BRANCH, c_S_JUMP:   w_next_state = c_S_FETCH;
            default:    w_next_state = c_S_HALT;   // HALT and unused encodings
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output (datapath control) logic
    // ------------------------------------------------------------------
    logic        w_ir_we, w_ab_we, w_mdr_we, w_mem_we, w_gpio_we;
    logic        w_pc_we, w_alu_we, w_rf_we, w_halted;
    logic [31:0] w_pc_d, w_alu_d, w_rf_data;
    logic [4:0]  w_rf_addr;

    always_comb begin
        w_ir_we   = 1'b0;
        w_ab_we   = 1'b0;
        w_mdr_we  = 1'b0;
        w_mem_we  = 1'b0;
        w_gpio_we = 1'b0;
        w_pc_we   = 1'b0;
        w_pc_d    = r_pc + 32'd4;
        w_alu_we  = 1'b0;
        w_alu_d   = r_a + w_sext;
        w_rf_we   = 1'b0;
        w_rf_addr = w_rt;
        w_rf_data = r_alu_out;
        w_halted  = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                w_ir_we = 1'b1;
                w_pc_we = 1'b1;
            end
            c_S_DECODE: begin
                // Branch target is precomputed here, PC already holds PC+4.
                w_ab_we  = 1'b1;
                w_alu_we = 1'b1;
                w_alu_d  = r_pc + {w_sext[29:0], 2'b00};
            end
            c_S_MEMADR: w_alu_we = 1'b1;
            c_S_MEMRD:  w_mdr_we = 1'b1;
            c_S_MEMWB: begin
                w_rf_we   = 1'b1;
                w_rf_data = r_mdr;
            end
            c_S_MEMWR: begin
                w_gpio_we = w_gpio_hit;
                w_mem_we  = !w_gpio_hit;
            end
            c_S_EXEC: begin
                w_alu_we = w_funct_ok;
                w_alu_d  = w_r_result;
            end
            c_S_ALUWB: begin
                w_rf_we   = 1'b1;
                w_rf_addr = w_rd;
            end
            c_S_IMMEX: begin
                w_alu_we = 1'b1;
                w_alu_d  = w_imm_result;
            end
            c_S_IMMWB:  w_rf_we = 1'b1;
            c_S_BRANCH: begin
                w_pc_we = w_br_taken;
                w_pc_d  = r_alu_out;
            end
            c_S_JUMP: begin
                w_pc_we = 1'b1;
                w_pc_d  = {r_pc[31:28], r_ir[25:0], 2'b00};
            end
            c_S_HALT:   w_halted = 1'b1;
            default:    w_halted = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0;
            r_mdr     <= 32'h0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_alu_out <= 32'h0;
            r_gpio    <= '0;
        end else begin
            if (w_ir_we)   r_ir      <= w_mem_pc_word;
            if (w_pc_we)   r_pc      <= w_pc_d;
            if (w_ab_we) begin
                r_a <= w_rs_val;
                r_b <= w_rt_val;
            end
            if (w_alu_we)  r_alu_out <= w_alu_d;
            if (w_mdr_we)  r_mdr     <= w_mem_alu_word;
            if (w_gpio_we) r_gpio    <= r_b[GPIO_W-1:0];
        end
    end

    // Register file: cleared on reset, writes to $0 dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else if (w_rf_we && (w_rf_addr != 5'd0)) begin
            r_regs[w_rf_addr] <= w_rf_data;
        end
    end

    // Memory has no reset; a store in flight is dropped if reset hits its edge.
    // A plain clocked process keeps the array open to external initialisation.
    always @(posedge clk) begin
        if (!reset && w_mem_we) r_mem[r_alu_out[c_AW+1:2]] <= r_b;
    end

    assign GPIO_o   = r_gpio;
    assign pc_o     = r_pc;
    assign state_o  = r_state;
    assign halted_o = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_mips_multi_cycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multi_cycle_core
// Purpose  : Self-checking bench for mips_multi_cycle_core. Each task loads a
//            small program, queues the results it expects, then runs the core
//            and compares architectural state at known cycle counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multi_cycle_core;
    localparam int c_DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  gpio;
    logic [31:0] pc;
    logic [3:0]  state;
    logic        halted;

    logic [31:0] sb_q [$];
    logic [31:0] exp;
    int          n_vec = 0;
    int          n_err = 0;

    mips_multi_cycle_core #(
        .MEM_DEPTH (c_DEPTH),
        .GPIO_W    (8),
        .GPIO_ADDR (32'h0000_0FFC),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .GPIO_o   (gpio),
        .pc_o     (pc),
        .state_o  (state),
        .halted_o (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        enc_r = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        enc_i = {op, rs[4:0], rt[4:0], imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        enc_j = {6'h02, tgt};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset, wipe memory (zero word decodes as unsupported funct -> HALT).
    task automatic hold_and_clear;
        reset = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) dut.r_mem[i] = 32'h0;
    endtask

    task automatic release_reset;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        hold_and_clear();
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        release_reset();
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({28'h0, state} !== exp) begin n_err++; $display("FAIL reset_state: got %h want %h", state, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({31'h0, halted} !== exp) begin n_err++; $display("FAIL reset_halted: got %h want %h", halted, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({24'h0, gpio} !== exp) begin n_err++; $display("FAIL reset_gpio: got %h want %h", gpio, exp); end
    endtask

    task automatic test_alu;
        hold_and_clear();
        dut.r_mem[0] = enc_i(6'h08, 0, 1, 16'd5);        // addi $1,$0,5
        dut.r_mem[1] = enc_i(6'h08, 0, 2, 16'hFFFD);     // addi $2,$0,-3
        dut.r_mem[2] = enc_r(1, 2, 3, 6'h20);            // add  $3,$1,$2
        dut.r_mem[3] = enc_r(2, 1, 4, 6'h2A);            // slt  $4,$2,$1
        dut.r_mem[4] = enc_r(1, 2, 7, 6'h22);            // sub  $7,$1,$2
        dut.r_mem[5] = enc_r(1, 2, 8, 6'h24);            // and  $8,$1,$2
        dut.r_mem[6] = enc_r(1, 2, 9, 6'h25);            // or   $9,$1,$2
        dut.r_mem[7] = enc_r(1, 2, 10, 6'h2A);           // slt  $10,$1,$2
        sb_q.push_back(32'd2); sb_q.push_back(32'h0000_000C); sb_q.push_back(32'd1);
        sb_q.push_back(32'd8); sb_q.push_back(32'd5); sb_q.push_back(32'hFFFF_FFFD); sb_q.push_back(32'd0);
        release_reset();
        tick(12);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[3] !== exp) begin n_err++; $display("FAIL alu_add: got %h want %h", dut.r_regs[3], exp); end
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL alu_pc: got %h want %h", pc, exp); end
        tick(4);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[4] !== exp) begin n_err++; $display("FAIL alu_slt_true: got %h want %h", dut.r_regs[4], exp); end
        tick(16);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[7] !== exp) begin n_err++; $display("FAIL alu_sub: got %h want %h", dut.r_regs[7], exp); end
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[8] !== exp) begin n_err++; $display("FAIL alu_and: got %h want %h", dut.r_regs[8], exp); end
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[9] !== exp) begin n_err++; $display("FAIL alu_or: got %h want %h", dut.r_regs[9], exp); end
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[10] !== exp) begin n_err++; $display("FAIL alu_slt_false: got %h want %h", dut.r_regs[10], exp); end
    endtask

    task automatic test_gpio;
        hold_and_clear();
        dut.r_mem[0]  = enc_i(6'h08, 0, 3, 16'h01A5);    // addi $3,$0,0x1A5
        dut.r_mem[1]  = enc_i(6'h2B, 0, 3, 16'h0FFC);    // sw   $3,0xFFC($0)
        dut.r_mem[63] = 32'hDEAD_BEEF;                   // word aliased by 0xFFC
        sb_q.push_back(32'd5); sb_q.push_back(32'h0); sb_q.push_back(32'hA5); sb_q.push_back(32'hDEAD_BEEF);
        release_reset();
        tick(7);
        exp = sb_q.pop_front(); n_vec++; if ({28'h0, state} !== exp) begin n_err++; $display("FAIL gpio_memwr_state: got %h want %h", state, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({24'h0, gpio} !== exp) begin n_err++; $display("FAIL gpio_before: got %h want %h", gpio, exp); end
        tick(1);
        exp = sb_q.pop_front(); n_vec++; if ({24'h0, gpio} !== exp) begin n_err++; $display("FAIL gpio_after: got %h want %h", gpio, exp); end
        exp = sb_q.pop_front(); n_vec++; if (dut.r_mem[63] !== exp) begin n_err++; $display("FAIL gpio_mem_untouched: got %h want %h", dut.r_mem[63], exp); end
    endtask

    task automatic test_load_store;
        hold_and_clear();
        dut.r_mem[0] = enc_i(6'h08, 0, 1, 16'd5);        // addi $1,$0,5
        dut.r_mem[1] = enc_i(6'h2B, 0, 1, 16'h0020);     // sw   $1,0x20($0)
        dut.r_mem[2] = enc_i(6'h23, 0, 5, 16'h0020);     // lw   $5,0x20($0)
        sb_q.push_back(32'd5);
        for (int s = 0; s < 5; s++) sb_q.push_back(s);
        sb_q.push_back(32'd0); sb_q.push_back(32'd5); sb_q.push_back(32'h0000_000C);
        release_reset();
        tick(8);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_mem[8] !== exp) begin n_err++; $display("FAIL sw_mem: got %h want %h", dut.r_mem[8], exp); end
        for (int s = 0; s < 5; s++) begin
            exp = sb_q.pop_front(); n_vec++;
            if ({28'h0, state} !== exp) begin n_err++; $display("FAIL lw_state_seq[%0d]: got %h want %h", s, state, exp); end
            tick(1);
        end
        exp = sb_q.pop_front(); n_vec++; if ({28'h0, state} !== exp) begin n_err++; $display("FAIL lw_done_state: got %h want %h", state, exp); end
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[5] !== exp) begin n_err++; $display("FAIL lw_data: got %h want %h", dut.r_regs[5], exp); end
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL lw_pc: got %h want %h", pc, exp); end
    endtask

    task automatic test_branch_jump;
        hold_and_clear();
        dut.r_mem[0]  = enc_i(6'h08, 0, 1, 16'd5);       // addi $1,$0,5
        dut.r_mem[1]  = enc_i(6'h08, 0, 2, 16'd1);       // addi $2,$0,1
        dut.r_mem[2]  = enc_i(6'h08, 2, 2, 16'd1);       // addi $2,$2,1
        dut.r_mem[3]  = enc_i(6'h08, 2, 2, 16'd1);       // addi $2,$2,1
        dut.r_mem[4]  = enc_i(6'h04, 1, 1, 16'd2);       // 0x10 beq $1,$1,+2 -> 0x1C
        dut.r_mem[5]  = enc_i(6'h08, 0, 11, 16'h0099);
        dut.r_mem[6]  = enc_i(6'h08, 0, 11, 16'h0098);
        dut.r_mem[7]  = enc_i(6'h05, 1, 1, 16'd2);       // 0x1C bne $1,$1,+2 -> 0x20
        dut.r_mem[8]  = enc_i(6'h05, 1, 2, 16'd1);       // 0x20 bne $1,$2,+1 -> 0x28
        dut.r_mem[9]  = enc_i(6'h08, 0, 11, 16'h0097);
        dut.r_mem[10] = enc_j(26'h40);                   // 0x28 j 0x40 -> 0x100
        sb_q.push_back(32'd3); sb_q.push_back(32'h1C); sb_q.push_back(32'h20);
        sb_q.push_back(32'h28); sb_q.push_back(32'h100); sb_q.push_back(32'h0);
        release_reset();
        tick(16);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[2] !== exp) begin n_err++; $display("FAIL br_setup: got %h want %h", dut.r_regs[2], exp); end
        tick(3);
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL beq_taken_pc: got %h want %h", pc, exp); end
        tick(3);
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL bne_not_taken_pc: got %h want %h", pc, exp); end
        tick(3);
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL bne_taken_pc: got %h want %h", pc, exp); end
        tick(3);
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL jump_pc: got %h want %h", pc, exp); end
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[11] !== exp) begin n_err++; $display("FAIL skipped_instr: got %h want %h", dut.r_regs[11], exp); end
    endtask

    task automatic test_halt;
        hold_and_clear();
        dut.r_mem[0] = enc_i(6'h08, 0, 1, 16'd5);        // addi $1,$0,5
        dut.r_mem[1] = enc_i(6'h2B, 0, 1, 16'h0FFC);     // sw $1 -> GPIO
        dut.r_mem[2] = 32'hFC00_0000;                    // opcode 0x3F
        sb_q.push_back(32'h5); sb_q.push_back(32'd1); sb_q.push_back(32'd15); sb_q.push_back(32'h0C);
        sb_q.push_back(32'h0C); sb_q.push_back(32'h5); sb_q.push_back(32'd1);
        sb_q.push_back(32'h0); sb_q.push_back(32'd0); sb_q.push_back(32'h0);
        release_reset();
        tick(8);
        exp = sb_q.pop_front(); n_vec++; if ({24'h0, gpio} !== exp) begin n_err++; $display("FAIL halt_pre_gpio: got %h want %h", gpio, exp); end
        tick(2);
        exp = sb_q.pop_front(); n_vec++; if ({31'h0, halted} !== exp) begin n_err++; $display("FAIL halt_flag: got %h want %h", halted, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({28'h0, state} !== exp) begin n_err++; $display("FAIL halt_state: got %h want %h", state, exp); end
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL halt_pc: got %h want %h", pc, exp); end
        tick(20);
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL halt_pc_frozen: got %h want %h", pc, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({24'h0, gpio} !== exp) begin n_err++; $display("FAIL halt_gpio_frozen: got %h want %h", gpio, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({31'h0, halted} !== exp) begin n_err++; $display("FAIL halt_absorbing: got %h want %h", halted, exp); end
        reset = 1'b1;
        release_reset();
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL halt_reset_pc: got %h want %h", pc, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({31'h0, halted} !== exp) begin n_err++; $display("FAIL halt_reset_flag: got %h want %h", halted, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({24'h0, gpio} !== exp) begin n_err++; $display("FAIL halt_reset_gpio: got %h want %h", gpio, exp); end

        // Unsupported R-type funct: EXEC detects it and halts without writing rd.
        hold_and_clear();
        dut.r_mem[0] = enc_r(1, 2, 3, 6'h03);
        sb_q.push_back(32'd1); sb_q.push_back(32'd15); sb_q.push_back(32'h4); sb_q.push_back(32'h0);
        release_reset();
        tick(3);
        exp = sb_q.pop_front(); n_vec++; if ({31'h0, halted} !== exp) begin n_err++; $display("FAIL funct_halt_flag: got %h want %h", halted, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({28'h0, state} !== exp) begin n_err++; $display("FAIL funct_halt_state: got %h want %h", state, exp); end
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL funct_halt_pc: got %h want %h", pc, exp); end
        tick(5);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[3] !== exp) begin n_err++; $display("FAIL funct_halt_no_write: got %h want %h", dut.r_regs[3], exp); end
    endtask

    task automatic test_reset_mid_store;
        hold_and_clear();
        dut.r_mem[0]  = enc_i(6'h08, 0, 3, 16'h01A5);
        dut.r_mem[1]  = enc_i(6'h2B, 0, 3, 16'h0FFC);    // GPIO store, interrupted
        dut.r_mem[2]  = enc_i(6'h2B, 0, 3, 16'h0010);
        sb_q.push_back(32'd5); sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'd0); sb_q.push_back(32'h0);
        release_reset();
        tick(7);
        exp = sb_q.pop_front(); n_vec++; if ({28'h0, state} !== exp) begin n_err++; $display("FAIL mid_memwr_state: got %h want %h", state, exp); end
        reset = 1'b1;
        release_reset();
        exp = sb_q.pop_front(); n_vec++; if ({24'h0, gpio} !== exp) begin n_err++; $display("FAIL mid_reset_gpio: got %h want %h", gpio, exp); end
        exp = sb_q.pop_front(); n_vec++; if (pc !== exp) begin n_err++; $display("FAIL mid_reset_pc: got %h want %h", pc, exp); end
        exp = sb_q.pop_front(); n_vec++; if ({28'h0, state} !== exp) begin n_err++; $display("FAIL mid_reset_state: got %h want %h", state, exp); end
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[3] !== exp) begin n_err++; $display("FAIL mid_reset_regs: got %h want %h", dut.r_regs[3], exp); end
    endtask

    task automatic test_imm_upper;
        hold_and_clear();
        dut.r_mem[0] = enc_i(6'h0F, 0, 6, 16'hABCD);     // lui $6,0xABCD
        dut.r_mem[1] = enc_i(6'h0D, 6, 6, 16'h1234);     // ori $6,$6,0x1234
        dut.r_mem[2] = enc_i(6'h08, 0, 0, 16'd5);        // addi $0,$0,5 (discarded)
        sb_q.push_back(32'hABCD_0000); sb_q.push_back(32'hABCD_1234); sb_q.push_back(32'h0);
        release_reset();
        tick(4);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[6] !== exp) begin n_err++; $display("FAIL lui: got %h want %h", dut.r_regs[6], exp); end
        tick(4);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[6] !== exp) begin n_err++; $display("FAIL ori: got %h want %h", dut.r_regs[6], exp); end
        tick(4);
        exp = sb_q.pop_front(); n_vec++; if (dut.r_regs[0] !== exp) begin n_err++; $display("FAIL reg0_write: got %h want %h", dut.r_regs[0], exp); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_gpio();
        test_load_store();
        test_branch_jump();
        test_halt();
        test_reset_mid_store();
        test_imm_upper();
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
